// File: rtl/video_timing_gen_pkg.sv
// Shared 720p60 raster constants and counter types for the video timing generator.
package video_timing_pkg;

    localparam int DEF_ACTIVE_H      = 1280;
    localparam int DEF_H_FRONT_PORCH = 110;
    localparam int DEF_H_SYNC_WIDTH  = 40;
    localparam int DEF_H_BACK_PORCH  = 220;
    localparam int DEF_ACTIVE_V      = 720;
    localparam int DEF_V_FRONT_PORCH = 5;
    localparam int DEF_V_SYNC_WIDTH  = 5;
    localparam int DEF_V_BACK_PORCH  = 20;
    localparam int DEF_FPS           = 60;

    localparam int DEF_H_TOTAL = DEF_ACTIVE_H + DEF_H_FRONT_PORCH + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;
    localparam int DEF_V_TOTAL = DEF_ACTIVE_V + DEF_V_FRONT_PORCH + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FC_W     = 6;

    typedef logic [HCOUNT_W-1:0] hcount_t;
    typedef logic [VCOUNT_W-1:0] vcount_t;
    typedef logic [FC_W-1:0]     fc_t;

endpackage

// File: rtl/video_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pattern stage and HDMI encoder.
interface video_timing_if;
    import video_timing_pkg::*;

    hcount_t hcount_out;
    vcount_t vcount_out;
    logic    hs_out;
    logic    vs_out;
    logic    ad_out;
    logic    nf_out;
    fc_t     fc_out;

    modport master (output hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out);
    modport slave  (input  hcount_out, vcount_out, hs_out, vs_out, ad_out, nf_out, fc_out);

endinterface

// File: rtl/video_timing_gen_mod_counter.sv
// Modulo-MOD counter with enable; wrap flags the increment that returns it to zero.
module mod_counter #(
    parameter int WIDTH = 8,
    parameter int MOD   = 256,
    parameter int INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    assign wrap = inc && (value == WIDTH'(MOD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= WIDTH'(INIT);
        end else if (inc) begin
            value <= wrap ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: position counters plus registered sync/active/new-frame decode.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int ACTIVE_H      = DEF_ACTIVE_H,
    parameter int H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
    parameter int H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int ACTIVE_V      = DEF_ACTIVE_V,
    parameter int V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
    parameter int V_BACK_PORCH  = DEF_V_BACK_PORCH,
    parameter int FPS           = DEF_FPS,
    parameter bit SYNC_POL      = 1'b1
) (
    input  logic            clk_pixel_in,
    input  logic            rst_in,
    video_timing_if.master  vid
);

    localparam int H_TOTAL = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam hcount_t H_ACT    = hcount_t'(ACTIVE_H);
    localparam hcount_t HS_START = hcount_t'(ACTIVE_H + H_FRONT_PORCH);
    localparam hcount_t HS_END   = hcount_t'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam vcount_t V_ACT    = vcount_t'(ACTIVE_V);
    localparam vcount_t VS_START = vcount_t'(ACTIVE_V + V_FRONT_PORCH);
    localparam vcount_t VS_END   = vcount_t'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH);

    hcount_t h, h_nxt;
    vcount_t v, v_nxt;
    fc_t     fc;
    logic    h_wrap, v_wrap, nf_nxt, fc_wrap_unused;

    // Position resets to the last pixel so the first edge after release lands on (0,0).
    mod_counter #(.WIDTH(HCOUNT_W), .MOD(H_TOTAL), .INIT(H_TOTAL - 1)) u_hcnt (
        .clk(clk_pixel_in), .rst(rst_in), .inc(1'b1), .value(h), .wrap(h_wrap)
    );

    mod_counter #(.WIDTH(VCOUNT_W), .MOD(V_TOTAL), .INIT(V_TOTAL - 1)) u_vcnt (
        .clk(clk_pixel_in), .rst(rst_in), .inc(h_wrap), .value(v), .wrap(v_wrap)
    );

    // Frame count steps on the same edge that raises nf_out, keeping the two aligned.
    mod_counter #(.WIDTH(FC_W), .MOD(FPS), .INIT(0)) u_fcnt (
        .clk(clk_pixel_in), .rst(rst_in), .inc(nf_nxt), .value(fc), .wrap(fc_wrap_unused)
    );

    always_comb begin
        h_nxt  = h_wrap ? '0 : h + 1'b1;
        v_nxt  = v;
        if (v_wrap) begin
            v_nxt = '0;
        end else if (h_wrap) begin
            v_nxt = v + 1'b1;
        end
        nf_nxt = (h_nxt == H_ACT) && (v_nxt == V_ACT);
    end

    // Output register: every flag is decoded from the position the counters move to on this edge.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            vid.hcount_out <= '0;
            vid.vcount_out <= '0;
            vid.hs_out     <= ~SYNC_POL;
            vid.vs_out     <= ~SYNC_POL;
            vid.ad_out     <= 1'b0;
            vid.nf_out     <= 1'b0;
        end else begin
            vid.hcount_out <= h_nxt;
            vid.vcount_out <= v_nxt;
            vid.hs_out     <= ((h_nxt >= HS_START) && (h_nxt < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vid.vs_out     <= ((v_nxt >= VS_START) && (v_nxt < VS_END)) ? SYNC_POL : ~SYNC_POL;
            vid.ad_out     <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
            vid.nf_out     <= nf_nxt;
        end
    end

    assign vid.fc_out = fc;

endmodule
